direction_input: RTL and testbench



---
 rtl/direction_pkg.sv | 20 ++
 rtl/debounce_bit.sv | 50 +++++
 rtl/direction_input.sv | 83 ++++++++
 tb/tb_direction_input.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/direction_pkg.sv
// Shared constants for the direction-button conditioner: bit positions,
// vector width and the move FSM state encoding.
package direction_pkg;

  localparam int DIR_WIDTH = 4;

  localparam int DIR_N = 3;
  localparam int DIR_S = 2;
  localparam int DIR_E = 1;
  localparam int DIR_W = 0;

  typedef logic [DIR_WIDTH-1:0] dir_vec_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

endpackage

// File: rtl/debounce_bit.sv
// One button: two-flop synchroniser followed by a saturating debounce counter
// that flips the stable level only after DEBOUNCE_CYCLES disagreeing samples.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // A sample that agrees with the stable level throws away any partial count,
  // so a bounce shorter than the window never reaches the flip.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/direction_input.sv
// Debounces four direction buttons and turns each clean single press into a
// one-cycle one-hot move pulse; chords are flagged via multi_err instead.
module direction_input
  import direction_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic multi_err,
  output logic busy
);

  dir_vec_t btn_raw;
  dir_vec_t stable;

  assign btn_raw[DIR_N] = btn_n;
  assign btn_raw[DIR_S] = btn_s;
  assign btn_raw[DIR_E] = btn_e;
  assign btn_raw[DIR_W] = btn_w;

  for (genvar i = 0; i < DIR_WIDTH; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk_i    (clk),
      .rst_ni   (reset),
      .btn_i    (btn_raw[i]),
      .stable_o (stable[i])
    );
  end

  state_e   state_q;
  dir_vec_t dir_q;
  logic     err_q;

  // Outputs default low every cycle so a pulse can only live for the single
  // IDLE->FIRE / IDLE->WAIT_REL transition that set it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      dir_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stable != '0) begin
            if ($onehot(stable)) begin
              state_q <= FIRE;
              dir_q   <= stable;
            end else begin
              state_q <= WAIT_REL;
              err_q   <= 1'b1;
            end
          end
        end
        FIRE:     state_q <= WAIT_REL;
        WAIT_REL: if (stable == '0) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign n         = dir_q[DIR_N];
  assign s         = dir_q[DIR_S];
  assign e         = dir_q[DIR_E];
  assign w         = dir_q[DIR_W];
  assign multi_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input: stimulus pushes expected pulses
// (pattern plus cycle) into a queue, a negedge monitor pops and compares.
module tb_direction_input;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic n, s, e, w, multi_err, busy;

  direction_input #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
    .n(n), .s(s), .e(e), .w(w), .multi_err(multi_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse pattern {multi_err, n, s, e, w}
  localparam logic [4:0] P_W = 5'b00001, P_E = 5'b00010, P_S = 5'b00100,
                         P_N = 5'b01000, P_M = 5'b10000;

  typedef struct { logic [4:0] vec; int at; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc=%0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] v, input int at);
    exp_t x;
    x.vec = v;
    x.at  = at;
    q.push_back(x);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_btn(input logic [4:0] v, input logic val);
    if (v[3]) btn_n = val;
    if (v[2]) btn_s = val;
    if (v[1]) btn_e = val;
    if (v[0]) btn_w = val;
  endtask

  always @(negedge clk) begin
    logic [4:0] o;
    exp_t x;
    o = {multi_err, n, s, e, w};
    if (o != 5'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got %b at cyc=%0d want none", o, cyc);
      end else begin
        x = q.pop_front();
        if (x.vec !== o || x.at != cyc) begin
          bad++;
          $display("FAIL pulse: got %b at cyc=%0d want %b at cyc=%0d", o, cyc, x.vec, x.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic [4:0] walk [3];
    walk[0] = P_E; walk[1] = P_S; walk[2] = P_E;

    // reset: outputs low, first with no buttons then with btn_e held
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) btn_e = 1'b1;
      @(negedge clk);
      chk("reset_outs", int'({n, s, e, w, multi_err, busy}), 0);
      @(posedge clk); #1;
    end
    btn_e = 1'b0;
    step(3);
    reset = 1'b1;
    step(5);

    // clean press: pulse 6 edges after first sample, busy until release done
    c = cyc;
    btn_e = 1'b1;
    push(P_E, c + 7);
    wait_to(c + 6); chk("clean_busy_pre", int'(busy), 0);
    wait_to(c + 7); chk("clean_busy_fire", int'(busy), 1);
    while (cyc < c + 12) begin @(posedge clk); #1; end
    btn_e = 1'b0;
    wait_to(c + 18); chk("clean_busy_rel", int'(busy), 1);
    wait_to(c + 19); chk("clean_busy_idle", int'(busy), 0);
    step(3);

    // bounce shorter than the debounce window never fires
    btn_s = 1'b1; step(3);
    btn_s = 1'b0; step(1);
    btn_s = 1'b1; step(3);
    btn_s = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("bounce_busy", int'(busy), 0);
    end
    step(2);

    // simultaneous n+w: multi_err only, then n alone fires
    c = cyc;
    btn_n = 1'b1; btn_w = 1'b1;
    push(P_M, c + 7);
    step(10);
    btn_n = 1'b0; btn_w = 1'b0;
    step(14);
    @(negedge clk); chk("multi_idle", int'(busy), 0);
    step(1);
    c = cyc;
    btn_n = 1'b1;
    push(P_N, c + 7);
    step(10);
    btn_n = 1'b0;
    step(14);

    // held overlap: e fires, later s while e held gives nothing
    c = cyc;
    btn_e = 1'b1;
    push(P_E, c + 7);
    step(8);
    btn_s = 1'b1;
    step(12);
    btn_e = 1'b0; btn_s = 1'b0;
    wait_to(c + 26); chk("overlap_busy_rel", int'(busy), 1);
    wait_to(c + 27); chk("overlap_idle", int'(busy), 0);
    step(3);

    // game walk e, s, e
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      set_btn(walk[i], 1'b1);
      push(walk[i], c + 7);
      step(8);
      set_btn(walk[i], 1'b0);
      step(14);
    end

    // reset 2 cycles into an n press aborts it; n held through release fires
    btn_n = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_outs", int'({n, s, e, w, multi_err, busy}), 0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    c = cyc;
    push(P_N, c + 7);
    wait_to(c + 7); chk("held_reset_busy", int'(busy), 1);
    step(3);
    btn_n = 1'b0;
    step(14);
    @(negedge clk); chk("final_idle", int'(busy), 0);
    step(5);

    chk("pending_expected", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
